// File: rtl/mips_mem_ctrl.sv
// mips_mem_ctrl: instruction/data RAMs plus an MMIO window (console FIFO, cycle counter) for a multi-cycle MIPS core.
// Optional cycle counter at FFFF_0008 is built only when MEM_CTRL_CYCLE_CNT_EN is defined.
module mips_mem_ctrl #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        bus_err
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);
    localparam int FA = $clog2(FIFO_DEPTH);

    logic [31:0]   imem [IMEM_WORDS];
    logic [31:0]   dmem [DMEM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FA-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FA:0]   count_q, count_d;
    logic          ovf_q, ovf_d, bus_err_q, bus_err_d;
    logic          is_mmio, is_dmem, empty, full, pop, push_req, push, mmio_wr;
    logic [13:0]   mmio_off;
    logic [7:0]    count_rd;
    logic [31:0]   mmio_rd, cycle_rd;
    logic          unused;

    assign unused      = ^{Address[1:0], PC[1:0], prog_addr[1:0]};
    assign is_mmio     = Address[31:16] == 16'hFFFF;
    assign is_dmem     = Address[31:DA+2] == '0;
    assign mmio_off    = Address[15:2];
    assign mmio_wr     = MemWrite && is_mmio;
    assign empty       = count_q == '0;
    assign full        = count_q == (FA+1)'(FIFO_DEPTH);
    assign pop         = !empty && con_ready;
    assign push_req    = mmio_wr && mmio_off == 14'd0;
    assign push        = push_req && (!full || pop);
    assign con_valid   = !empty;
    assign con_data    = empty ? 8'h0 : fifo[rd_ptr_q];
    assign bus_err     = bus_err_q;
    assign count_rd    = 8'(count_q);
    assign Instruction = (PC[31:IA+2] == '0) ? imem[PC[IA+1:2]] : 32'h0;

    // MMIO and load-data read mux; reads see state before this cycle's write
    always_comb begin
        mmio_rd   = (mmio_off == 14'd0) ? {24'b0, con_data} :
                    (mmio_off == 14'd1) ? {16'b0, count_rd, 5'b0, ovf_q, full, empty} :
                    (mmio_off == 14'd2) ? cycle_rd : 32'h0;
        Read_data = !MemRead ? 32'h0 : is_mmio ? mmio_rd : is_dmem ? dmem[Address[DA+1:2]] : 32'h0;
    end

    // FIFO pointer/count, overflow and sticky bus error next state
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + (FA+1)'(push) - (FA+1)'(pop);
        ovf_d     = (push_req && !push) ? 1'b1 : (mmio_wr && mmio_off == 14'd1) ? 1'b0 : ovf_q;
        bus_err_d = bus_err_q | ((MemRead | MemWrite) & !is_mmio & !is_dmem);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Program load into IMEM, suppressed while reset is held
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && prog_we && prog_addr[31:IA+2] == '0) imem[prog_addr[IA+1:2]] <= prog_data;
    end

    // Data RAM and console FIFO storage writes
    always_ff @(posedge clk) begin
        if (MemWrite && is_dmem) dmem[Address[DA+1:2]] <= Write_data;
        if (push) fifo[wr_ptr_q] <= Write_data[7:0];
    end

`ifdef MEM_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    // Free-running counter; a CYCLE write wins over the increment
    always_comb cycle_d = (mmio_wr && mmio_off == 14'd2) ? 32'h0 : cycle_q + 32'd1;

    // Cycle counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_d;
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = 32'h0;
`endif
endmodule

// File: tb/tb_mips_mem_ctrl.sv
// tb_mips_mem_ctrl: scoreboard bench with a queue/array reference model of the memory controller.
module tb_mips_mem_ctrl;
    localparam int IW = 256, DW = 256, FD = 8;

    logic clk, rst, mem_rd, mem_wr, prog_we, con_ready, con_valid, bus_err;
    logic [31:0] pc, instr, addr, wdata, rdata, prog_addr, prog_data;
    logic [7:0] con_data;
    int vectors = 0, miscompares = 0;

    mips_mem_ctrl #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .PC(pc), .Instruction(instr), .Address(addr),
        .MemRead(mem_rd), .MemWrite(mem_wr), .Write_data(wdata), .Read_data(rdata),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready), .bus_err(bus_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rd;
        logic        cv;
        logic [7:0]  cd;
        logic        be;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] imem_m [IW];
    logic [31:0] dmem_m [DW];
    logic [7:0]  fifo_m[$];
    logic        ovf_m, berr_m;
    logic [31:0] cyc_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [7:0] head, cnt;
        head = fifo_m.size() > 0 ? fifo_m[0] : 8'h0;
        cnt = 8'(fifo_m.size());
        if (a[31:16] == 16'hFFFF) begin
            if (a[15:2] == 14'd0) return {24'b0, head};
            if (a[15:2] == 14'd1) return {16'b0, cnt, 5'b0, ovf_m, fifo_m.size() == FD, fifo_m.size() == 0};
`ifdef MEM_CTRL_CYCLE_CNT_EN
            if (a[15:2] == 14'd2) return cyc_m;
`endif
            return 0;
        end
        if (a < 4 * DW) return dmem_m[a >> 2];
        return 0;
    endfunction

    task automatic reset_model();
        fifo_m.delete();
        ovf_m = 0;
        berr_m = 0;
        cyc_m = 0;
    endtask

    // One clock: record expected outputs for this cycle, then advance the model past the edge.
    task automatic step();
        exp_t e;
        bit mmio, pop, preq;
        mmio = addr[31:16] == 16'hFFFF;
        e.ins = (pc < 4 * IW) ? imem_m[pc >> 2] : 32'h0;
        e.rd = mem_rd ? model_rd(addr) : 32'h0;
        e.cv = fifo_m.size() > 0;
        e.cd = e.cv ? fifo_m[0] : 8'h0;
        e.be = berr_m;
        exp_q.push_back(e);
        pop = fifo_m.size() > 0 && con_ready;
        preq = mem_wr && mmio && addr[15:2] == 14'd0;
        if ((mem_rd || mem_wr) && !mmio && addr >= 4 * DW) berr_m = 1;
        if (mem_wr && !mmio && addr < 4 * DW) dmem_m[addr >> 2] = wdata;
        if (prog_we && prog_addr < 4 * IW) imem_m[prog_addr >> 2] = prog_data;
        if (mem_wr && mmio && addr[15:2] == 14'd1) ovf_m = 0;
        if (pop) void'(fifo_m.pop_front());
        if (preq) begin
            if (fifo_m.size() < FD) fifo_m.push_back(wdata[7:0]);
            else ovf_m = 1;
        end
        cyc_m = (mem_wr && mmio && addr[15:2] == 14'd2) ? 32'h0 : cyc_m + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
        addr = a; mem_rd = r; mem_wr = w; wdata = d;
        step();
        mem_rd = 0; mem_wr = 0; prog_we = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("async_con_valid", {31'b0, con_valid}, 32'h0);
        chk("async_con_data", {24'b0, con_data}, 32'h0);
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Monitor: pops one expectation per checked cycle, independent of the stimulus flow
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instruction", instr, e.ins);
            chk("read_data", rdata, e.rd);
            chk("con_valid", {31'b0, con_valid}, {31'b0, e.cv});
            chk("con_data", {24'b0, con_data}, {24'b0, e.cd});
            chk("bus_err", {31'b0, bus_err}, {31'b0, e.be});
        end
    end

    initial begin
        rst = 1; pc = 0; addr = 0; mem_rd = 0; mem_wr = 0; wdata = 0;
        prog_we = 0; prog_addr = 0; prog_data = 0; con_ready = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_con_valid", {31'b0, con_valid}, 32'h0);
        chk("reset_bus_err", {31'b0, bus_err}, 32'h0);
        for (int i = 0; i < 256; i++) begin
            prog_we = 1; prog_addr = i * 4; prog_data = $urandom;
            op(i * 4, 0, 1, $urandom);
        end
        // program load and fetch, including out-of-range PC
        for (int i = 0; i < 3; i++) begin
            prog_we = 1; prog_addr = i * 4; prog_data = 32'h1111_1111 * (i + 1);
            op(0, 0, 0, 0);
        end
        pc = 4;      op(0, 0, 0, 0);
        pc = 4 * IW; op(0, 0, 0, 0);
        pc = 0;
        // data RAM store/load and unmapped write
        op(32'h10, 0, 1, 32'hDEADBEEF);
        op(32'h10, 1, 0, 0);
        op(32'h10, 1, 1, 32'h1234_5678);
        op(32'h8000_0000, 0, 1, 32'h5);
        op(32'h10, 1, 0, 0);
        op(0, 0, 0, 0);
        // overflow, ovf clear, drain
        con_ready = 0;
        for (int i = 0; i <= FD; i++) op(32'hFFFF_0000, 0, 1, 32'h30 + i);
        op(32'hFFFF_0004, 1, 0, 0);
        op(32'hFFFF_0004, 0, 1, 0);
        op(32'hFFFF_0004, 1, 0, 0);
        op(32'hFFFF_0000, 1, 0, 0);
        con_ready = 1;
        for (int i = 0; i < FD + 1; i++) op(32'hFFFF_0004, 1, 0, 0);
        // full FIFO with same-cycle pop accepts the push
        con_ready = 0;
        for (int i = 0; i < FD; i++) op(32'hFFFF_0000, 0, 1, 32'h50 + i);
        con_ready = 1;
        op(32'hFFFF_0000, 0, 1, 32'h41);
        con_ready = 0;
        op(32'hFFFF_0004, 1, 0, 0);
        con_ready = 1;
        for (int i = 0; i < FD + 1; i++) op(32'hFFFF_0000, 1, 0, 0);
        // async reset with queued bytes
        con_ready = 0;
        for (int i = 0; i < 3; i++) op(32'hFFFF_0000, 0, 1, 32'h70 + i);
        op(32'h8000_0000, 1, 0, 0);
        do_reset();
        op(32'hFFFF_0004, 1, 0, 0);
        // cycle counter
        do_reset();
        for (int i = 0; i < 99; i++) op(0, 0, 0, 0);
        op(32'hFFFF_0008, 1, 0, 0);
        op(32'hFFFF_0008, 0, 1, 32'hFFFF_FFFF);
        op(32'hFFFF_0008, 1, 0, 0);
        for (int i = 0; i < 5; i++) op(0, 0, 0, 0);
        op(32'hFFFF_0008, 1, 0, 0);
        op(32'hFFFF_000C, 1, 1, 32'h99);
        // randomized mix
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = (r < 5) ? ($urandom_range(0, DW - 1) * 4 + $urandom_range(0, 3)) :
                (r < 9) ? (32'hFFFF_0000 + $urandom_range(0, 4) * 4) : (32'h0001_0000 + $urandom_range(0, 255));
            con_ready = $urandom_range(0, 2) != 0;
            pc = $urandom_range(0, IW + 15) * 4;
            prog_we = $urandom_range(0, 3) == 0;
            prog_addr = $urandom_range(0, IW + 3) * 4;
            prog_data = $urandom;
            op(a, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        end
        con_ready = 1;
        for (int i = 0; i < FD + 2; i++) op(32'hFFFF_0004, 1, 0, 0);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
